fp_addsub_pipe: RTL and testbench

Parametrised, pipelined IEEE-754-style floating-point adder/subtractor; successor to the single-cycle FP32 adder in the FPU datapath.
- Adds configurable exponent/mantissa widths and a runtime subtract mode.
- Adds round-to-nearest-even with guard/round/sticky bits.
- Adds a valid/ready handshake with backpressure and a full exception flag set.
- Fixed 3-stage pipeline; sits between the operand register file and the result writeback arbiter.

---
 rtl/fp_addsub_pipe.sv | 217 +++++++++++++++++++++
 tb/tb_fp_addsub_pipe.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with round-to-nearest-even,
// DAZ/FTZ handling, IEEE exception flags and a globally stalled valid/ready handshake.
module fp_addsub_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [EXP_W+MAN_W:0]   i_a,
    input  logic [EXP_W+MAN_W:0]   i_b,
    input  logic                   i_sub,
    input  logic                   i_vld,
    output logic                   i_rdy,
    output logic [EXP_W+MAN_W:0]   o_res,
    output logic                   o_res_vld,
    input  logic                   o_rdy,
    output logic                   o_overflow,
    output logic                   o_underflow,
    output logic                   o_invalid,
    output logic                   o_inexact
);
    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int unsigned SW    = MAN_W + 4;  // hidden + fraction + G/R/S
    localparam int unsigned LZ_W  = $clog2(SW + 1);
    localparam int unsigned EW    = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;

    logic w_adv;
    assign w_adv = !o_res_vld || o_rdy;
    assign i_rdy = w_adv;

    // ---------------- stage 1: classify / swap / align ----------------
    logic             w_a_sign, w_b_sign;
    logic [EXP_W-1:0] w_a_exp, w_b_exp;
    logic [MAN_W-1:0] w_a_frac, w_b_frac;
    logic             w_a_zero, w_b_zero, w_a_max, w_b_max;
    logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf;
    logic [MAN_W:0]   w_a_sig, w_b_sig;
    logic             w_a_ge_b;

    assign w_a_sign = i_a[W-1];
    assign w_b_sign = i_b[W-1] ^ i_sub;
    assign w_a_exp  = i_a[W-2:MAN_W];
    assign w_b_exp  = i_b[W-2:MAN_W];
    assign w_a_frac = i_a[MAN_W-1:0];
    assign w_b_frac = i_b[MAN_W-1:0];
    assign w_a_zero = (w_a_exp == '0);
    assign w_b_zero = (w_b_exp == '0);
    assign w_a_max  = &w_a_exp;
    assign w_b_max  = &w_b_exp;
    assign w_a_nan  = w_a_max && (w_a_frac != '0);
    assign w_b_nan  = w_b_max && (w_b_frac != '0);
    assign w_a_inf  = w_a_max && (w_a_frac == '0);
    assign w_b_inf  = w_b_max && (w_b_frac == '0);
    // Subnormals are flushed: a zero exponent contributes no significand at all.
    assign w_a_sig  = w_a_zero ? '0 : {1'b1, w_a_frac};
    assign w_b_sig  = w_b_zero ? '0 : {1'b1, w_b_frac};
    assign w_a_ge_b = {w_a_exp, w_a_sig} >= {w_b_exp, w_b_sig};

    logic             w_big_sign, w_sml_sign;
    logic [EXP_W-1:0] w_big_exp, w_sml_exp, w_diff;
    logic [MAN_W:0]   w_big_sig, w_sml_sig;
    logic [SW-1:0]    w_sml_ext, w_sml_shf, w_sml_aln;
    logic             w_sticky;

    assign w_big_sign = w_a_ge_b ? w_a_sign : w_b_sign;
    assign w_sml_sign = w_a_ge_b ? w_b_sign : w_a_sign;
    assign w_big_exp  = w_a_ge_b ? w_a_exp  : w_b_exp;
    assign w_sml_exp  = w_a_ge_b ? w_b_exp  : w_a_exp;
    assign w_big_sig  = w_a_ge_b ? w_a_sig  : w_b_sig;
    assign w_sml_sig  = w_a_ge_b ? w_b_sig  : w_a_sig;
    assign w_diff     = w_big_exp - w_sml_exp;
    assign w_sml_ext  = {w_sml_sig, 3'b000};
    assign w_sml_shf  = w_sml_ext >> w_diff;
    assign w_sticky   = |(w_sml_ext & ~({SW{1'b1}} << w_diff));
    assign w_sml_aln  = {w_sml_shf[SW-1:1], w_sml_shf[0] | w_sticky};

    logic         w_spec_nan, w_spec;
    logic [W-1:0] w_spec_res;

    assign w_spec_nan = w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_a_sign != w_b_sign));
    assign w_spec     = w_spec_nan || w_a_inf || w_b_inf;
    assign w_spec_res = w_spec_nan ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}} :
                        w_a_inf    ? {w_a_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}} :
                                     {w_b_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

    logic             r1_vld, r1_sign, r1_same, r1_spec, r1_spec_inv;
    logic [EXP_W-1:0] r1_exp;
    logic [SW-1:0]    r1_big, r1_sml;
    logic [W-1:0]     r1_spec_res;

    // ---------------- stage 2: add / subtract / leading-zero count ----------------
    logic [SW:0]     w_sum;
    logic [LZ_W-1:0] w_lzc;

    assign w_sum = r1_same ? ({1'b0, r1_big} + {1'b0, r1_sml})
                           : ({1'b0, r1_big} - {1'b0, r1_sml});

    always_comb begin
        w_lzc = LZ_W'(SW);
        for (int i = 0; i < int'(SW); i++) begin
            if (w_sum[i]) w_lzc = LZ_W'(SW - 1 - i);
        end
    end

    logic             r2_vld, r2_sign, r2_same, r2_spec, r2_spec_inv;
    logic [EXP_W-1:0] r2_exp;
    logic [SW:0]      r2_sum;
    logic [LZ_W-1:0]  r2_lzc;
    logic [W-1:0]     r2_spec_res;

    // ---------------- stage 3: normalise / round / pack ----------------
    logic [SW-1:0]    w_norm;
    logic [EW-1:0]    w_exp_n, w_exp_f;
    logic             w_g, w_r, w_s, w_inc;
    logic [MAN_W+1:0] w_rnd;
    logic [MAN_W-1:0] w_frac;
    logic [W-1:0]     w_res;
    logic             w_ovf, w_unf, w_inv, w_inx;
    logic             w_unused;

    always_comb begin
        if (r2_sum[SW]) begin
            w_norm  = {r2_sum[SW:2], r2_sum[1] | r2_sum[0]};
            w_exp_n = EW'(r2_exp) + EW'(1);
        end else begin
            w_norm  = r2_sum[SW-1:0] << r2_lzc;
            w_exp_n = EW'(r2_exp) - EW'(r2_lzc);
        end
    end

    assign w_g      = w_norm[2];
    assign w_r      = w_norm[1];
    assign w_s      = w_norm[0];
    assign w_inc    = w_g && (w_r || w_s || w_norm[3]);
    assign w_rnd    = {1'b0, w_norm[SW-1:3]} + (MAN_W+2)'(w_inc);
    // A carry out of rounding leaves 1.000..0, so the fraction becomes zero.
    assign w_exp_f  = w_exp_n + EW'(w_rnd[MAN_W+1]);
    assign w_frac   = w_rnd[MAN_W+1] ? '0 : w_rnd[MAN_W-1:0];
    assign w_unused = w_rnd[MAN_W];

    always_comb begin
        w_res = {r2_sign, w_exp_f[EXP_W-1:0], w_frac};
        w_ovf = 1'b0;
        w_unf = 1'b0;
        w_inv = 1'b0;
        w_inx = w_g || w_r || w_s;
        if (r2_spec) begin
            w_res = r2_spec_res;
            w_inv = r2_spec_inv;
            w_inx = 1'b0;
        end else if (r2_sum == '0) begin
            // Only like-signed zeros keep their sign; any cancellation yields +0.
            w_res = {r2_sign && r2_same, {(W-1){1'b0}}};
            w_inx = 1'b0;
        end else if (!w_exp_f[EW-1] && (w_exp_f >= EW'({EXP_W{1'b1}}))) begin
            w_res = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_ovf = 1'b1;
            w_inx = 1'b1;
        end else if (w_exp_f[EW-1] || (w_exp_f == '0)) begin
            w_res = {r2_sign, {(W-1){1'b0}}};
            w_unf = 1'b1;
            w_inx = 1'b1;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_vld      <= 1'b0;
            r2_vld      <= 1'b0;
            o_res_vld   <= 1'b0;
            o_res       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
            o_invalid   <= 1'b0;
            o_inexact   <= 1'b0;
        end else if (w_adv) begin
            r1_vld    <= i_vld;
            r2_vld    <= r1_vld;
            o_res_vld <= r2_vld;
            if (r2_vld) begin
                o_res       <= w_res;
                o_overflow  <= w_ovf;
                o_underflow <= w_unf;
                o_invalid   <= w_inv;
                o_inexact   <= w_inx;
            end else begin
                o_overflow  <= 1'b0;
                o_underflow <= 1'b0;
                o_invalid   <= 1'b0;
                o_inexact   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r1_sign     <= w_big_sign;
            r1_same     <= (w_big_sign == w_sml_sign);
            r1_exp      <= w_big_exp;
            r1_big      <= {w_big_sig, 3'b000};
            r1_sml      <= w_sml_aln;
            r1_spec     <= w_spec;
            r1_spec_inv <= w_spec_nan;
            r1_spec_res <= w_spec_res;
            r2_sign     <= r1_sign;
            r2_same     <= r1_same;
            r2_exp      <= r1_exp;
            r2_sum      <= w_sum;
            r2_lzc      <= w_lzc;
            r2_spec     <= r1_spec;
            r2_spec_inv <= r1_spec_inv;
            r2_spec_res <= r1_spec_res;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed bench for fp_addsub_pipe: FP32 and half-precision instances, hand-computed results,
// backpressure stream and mid-stream reset.
module tb_fp_addsub_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // FP32 instance
    logic [31:0] f_a, f_b, f_res;
    logic        f_sub, f_vld, f_irdy, f_rvld, f_ordy, f_ovf, f_unf, f_inv, f_inx;
    // Half-precision instance
    logic [15:0] h_a, h_b, h_res;
    logic        h_sub, h_vld, h_irdy, h_rvld, h_ordy, h_ovf, h_unf, h_inv, h_inx;

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) u_f32 (
        .clk(clk), .rst(rst), .i_a(f_a), .i_b(f_b), .i_sub(f_sub), .i_vld(f_vld),
        .i_rdy(f_irdy), .o_res(f_res), .o_res_vld(f_rvld), .o_rdy(f_ordy),
        .o_overflow(f_ovf), .o_underflow(f_unf), .o_invalid(f_inv), .o_inexact(f_inx)
    );

    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) u_f16 (
        .clk(clk), .rst(rst), .i_a(h_a), .i_b(h_b), .i_sub(h_sub), .i_vld(h_vld),
        .i_rdy(h_irdy), .o_res(h_res), .o_res_vld(h_rvld), .o_rdy(h_ordy),
        .o_overflow(h_ovf), .o_underflow(h_unf), .o_invalid(h_inv), .o_inexact(h_inx)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic        sel_half = 1'b0;
    logic [31:0] m_res;
    logic        m_vld;
    logic [3:0]  m_flg;
    assign m_res = sel_half ? {16'h0, h_res} : f_res;
    assign m_vld = sel_half ? h_rvld : f_rvld;
    assign m_flg = sel_half ? {h_ovf, h_unf, h_inv, h_inx} : {f_ovf, f_unf, f_inv, f_inx};

    // B operands k = 0..7 and the expected sums 1.0 + k
    logic [31:0] kval [8] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};
    logic [31:0] kexp [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    logic        bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One isolated operation; flags are {overflow, underflow, invalid, inexact}.
    task automatic run_op(input bit half, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic [31:0] exp_res,
                          input logic [3:0] exp_flg, input string tag);
        int cyc;
        sel_half = half;
        @(posedge clk); #1;
        if (half) begin
            h_a = a[15:0]; h_b = b[15:0]; h_sub = sub; h_vld = 1'b1;
        end else begin
            f_a = a; f_b = b; f_sub = sub; f_vld = 1'b1;
        end
        @(posedge clk); #1;
        f_vld = 1'b0;
        h_vld = 1'b0;
        cyc = 1;
        while (!m_vld && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'd3);
        check({tag, " res"}, m_res, exp_res);
        check({tag, " flags"}, {28'h0, m_flg}, {28'h0, exp_flg});
    endtask

    int          sent, recv;
    logic        held;
    logic [31:0] held_res;

    initial begin
        rst = 1'b1;
        f_a = '0; f_b = '0; f_sub = 1'b0; f_vld = 1'b0; f_ordy = 1'b1;
        h_a = '0; h_b = '0; h_sub = 1'b0; h_vld = 1'b0; h_ordy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset res", f_res, 32'h0);
        check("reset vld", {31'h0, f_rvld}, 32'h0);
        check("reset flags", {28'h0, f_ovf, f_unf, f_inv, f_inx}, 32'h0);
        check("reset i_rdy", {31'h0, f_irdy}, 32'h1);
        rst = 1'b0;

        // Basic arithmetic and rounding
        run_op(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, "1+2");
        run_op(0, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000, "3-1");
        run_op(0, 32'h3F800000, 32'h40400000, 1'b1, 32'hC0000000, 4'b0000, "1-3");
        run_op(0, 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, "1-1");
        run_op(0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, "tie even");
        run_op(0, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, "tie odd");
        run_op(0, 32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001, "above half");

        // Exceptions and zeros
        run_op(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1001, "overflow");
        run_op(0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0010, "inf-inf");
        run_op(0, 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0010, "nan in");
        run_op(0, 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, "inf+1");
        run_op(0, 32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000, "1-inf");
        run_op(0, 32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, "daz");
        run_op(0, 32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0101, "underflow");
        run_op(0, 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, "-0+-0");
        run_op(0, 32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, "-0++0");

        // Backpressure stream of eight 1.0+k operations
        sel_half = 1'b0;
        sent = 0;
        recv = 0;
        held = 1'b0;
        held_res = '0;
        for (int c = 0; c < 80 && recv < 8; c++) begin
            @(posedge clk); #1;
            if (held) begin
                check("bp hold res", f_res, held_res);
                check("bp hold vld", {31'h0, f_rvld}, 32'h1);
            end
            f_ordy = bp_pat[c % 4];
            f_vld  = (sent < 8);
            f_sub  = 1'b0;
            f_a    = 32'h3F800000;
            f_b    = (sent < 8) ? kval[sent] : 32'h0;
            #1;
            check("bp i_rdy", {31'h0, f_irdy}, {31'h0, !(f_rvld && !f_ordy)});
            held     = f_rvld && !f_ordy;
            held_res = f_res;
            if (f_rvld && f_ordy) begin
                check("bp res", f_res, (recv < 8) ? kexp[recv] : 32'hDEADBEEF);
                recv++;
            end
            if (f_vld && f_irdy) sent++;
        end
        f_vld  = 1'b0;
        f_ordy = 1'b1;
        check("bp recv count", 32'(recv), 32'd8);
        check("bp sent count", 32'(sent), 32'd8);
        repeat (5) @(posedge clk);
        #1;
        check("bp no dup", {31'h0, f_rvld}, 32'h0);

        // Reset with three overflowing operations in flight
        @(posedge clk); #1;
        f_a = 32'h7F7FFFFF; f_b = 32'h7F7FFFFF; f_sub = 1'b0; f_vld = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        f_vld = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst vld", {31'h0, f_rvld}, 32'h0);
        check("rst flags", {28'h0, f_ovf, f_unf, f_inv, f_inx}, 32'h0);
        check("rst res", f_res, 32'h0);
        run_op(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, "post rst");

        // Half precision
        run_op(1, 32'h3C00, 32'h3C00, 1'b0, 32'h4000, 4'b0000, "h 1+1");
        run_op(1, 32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 4'b1001, "h overflow");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
